watch_time_ctrl: RTL
====================

Name: watch_time_ctrl

Overview:
- Timekeeping and set-mode controller for the ASIC watch.
- Consumes the 1 Hz tick derived from the 32.768 kHz crystal divider, plus two debounced user buttons.
- Sequences the seconds/minutes/hours counters and owns the time-setting state machine.
- Drives the display blink enable; all logic runs in the crystal clock domain.

Parameters:
HOURS_MOD, 24, hour wrap modulus (24 or 12; 12 mode counts 0..11)
SET_TIMEOUT_S, 30, seconds without a button press before set mode auto-exits to RUN (1..63)

Ports:
clk_i  in  1  32.768 kHz crystal clock
rst_i  in  1  reset, asynchronous, active-high
tick_i  in  1  1 Hz strobe, single clk_i cycle, synchronous to clk_i
btn_mode_i  in  1  mode button, debounced single-cycle pulse
btn_inc_i  in  1  increment button, debounced single-cycle pulse
sec_o  out  6  seconds, binary 0..59
min_o  out  6  minutes, binary 0..59
hour_o  out  5  hours, binary 0..HOURS_MOD-1
mode_o  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
blink_o  out  1  display blink for the field being set; 0 in RUN

Behaviour:
- Reset (async): sec/min/hour=0, mode=RUN, blink_o=0, timeout counter=0. Reset mid-set returns to RUN at 00:00:00.
- All outputs are registered; a qualifying input pulse at cycle N is visible at cycle N+1.
- RUN:
  - tick_i increments sec.
  - sec 59 -> 0 carries into min; min 59 -> 0 carries into hour; hour HOURS_MOD-1 -> 0.
  - A full 23:59:59 -> 00:00:00 rollover completes in one cycle.
  - btn_inc_i is ignored.
  - btn_mode_i -> SET_HOUR.
- SET_HOUR:
  - btn_inc_i: hour+1 mod HOURS_MOD, with no carry into any other field.
  - btn_mode_i -> SET_MIN.
- SET_MIN:
  - btn_inc_i: min+1 mod 60, with no carry into hour.
  - btn_mode_i -> RUN and sec cleared to 0 in the same cycle.
- Time is frozen in SET states: tick_i does not advance sec.
- In SET states, tick_i toggles blink_o and increments the timeout counter.
- Entering a SET state forces blink_o=1.
- Any button press clears the timeout counter.
- Timeout: when the counter reaches SET_TIMEOUT_S on a tick, go to RUN.
  - sec is not cleared on timeout; the set values are kept.
  - blink_o=0 and the counter is cleared.
- Simultaneous events:
  - btn_mode_i with btn_inc_i: mode wins, inc is dropped.
  - btn_mode_i with a tick that would hit the timeout: the button wins (normal transition, counter cleared).
  - tick_i with btn_inc_i in a SET state: inc applied, blink toggles, timeout counter cleared.
  - tick_i with btn_mode_i in RUN: sec advances (including carries) and the state moves to SET_HOUR in the same cycle.
- State encoding value 3 is illegal; if reached, recover to RUN on the next cycle.
- The timeout counter is 6 bits and saturates; it never wraps.

Decomposition:
- Shared header/package: mode encodings (MODE_RUN/MODE_SET_HOUR/MODE_SET_MIN), SEC_MOD=60, MIN_MOD=60, field widths.
- One sub-module, mod_counter: parameterized modulo-N counter.
  - Inputs: inc_en, clear.
  - Outputs: value and carry_o.
  - carry_o = inc_en && value==N-1.
- Three instances (sec, min, hour). The controller gates inc_en per mode and chains carries only in RUN.

Test Plan:
- Reset then 61 ticks -> sec_o=1, min_o=1, hour_o=0, mode_o=0, blink_o=0.
- Preload 23:59:59 via set mode, then 1 tick in RUN -> 00:00:00 on the next cycle. Repeat with HOURS_MOD=12 from 11:59:59 -> 00:00:00.
- Set sequence from 00:00:37:
  - mode -> mode_o=1, blink_o=1.
  - 5 inc -> hour_o=5.
  - mode -> mode_o=2.
  - 61 inc -> min_o=1, hour_o=5 (no carry).
  - mode -> mode_o=0, sec_o=0, time 05:01:00.
- Timeout: enter SET_HOUR, 30 ticks with no buttons -> mode_o=0 after tick 30, blink_o=0. blink_o toggles on each tick before that. sec_o unchanged throughout.
- Simultaneity:
  - mode+inc same cycle in RUN -> SET_HOUR, hour unchanged.
  - tick+inc same cycle in SET_MIN -> min+1, timeout cleared, blink toggled.
- Async reset asserted mid SET_MIN with min_o=17 -> all outputs 0 immediately, mode_o=0. After release, ticks count from 00:00:00.

Source files
------------

// File: rtl/watch_time_ctrl_pkg.sv
// Shared encodings and field widths for the watch timekeeping controller.
package watch_time_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_ILLEGAL  = 2'd3
    } mode_e;

    localparam int SEC_MOD   = 60;
    localparam int MIN_MOD   = 60;
    localparam int SEC_W     = 6;
    localparam int MIN_W     = 6;
    localparam int HOUR_W    = 5;
    localparam int TIMEOUT_W = 6;

endpackage

// File: rtl/watch_time_ctrl_mod_counter.sv
// Modulo-N counter with synchronous clear and a combinational wrap carry.
module mod_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_en,
    input  logic         clear,
    output logic [W-1:0] value,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign carry_o = inc_en && (value == LAST);

    // Clear has priority; otherwise step and wrap from N-1 back to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc_en) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/watch_time_ctrl.sv
// Watch timekeeping: seconds/minutes/hours chain plus the time-setting state machine.
module watch_time_ctrl
    import watch_time_ctrl_pkg::*;
#(
    parameter int HOURS_MOD     = 24,
    parameter int SET_TIMEOUT_S = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [4:0] hour_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(SET_TIMEOUT_S);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX   = '1;

    mode_e                state;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [TIMEOUT_W-1:0] timeout_next;
    logic                 in_run;
    logic                 in_set_hour;
    logic                 in_set_min;
    logic                 sec_inc;
    logic                 min_inc;
    logic                 hour_inc;
    logic                 sec_clear;
    logic                 sec_carry;
    logic                 min_carry;
    logic                 hour_carry_unused;

    assign in_run      = (state == MODE_RUN);
    assign in_set_hour = (state == MODE_SET_HOUR);
    assign in_set_min  = (state == MODE_SET_MIN);

    // Carries only chain while running; in set mode the inc button steps one field
    // on its own, and a simultaneous mode press swallows the inc.
    assign sec_inc   = in_run && tick_i;
    assign min_inc   = (in_run && sec_carry) || (in_set_min && btn_inc_i && !btn_mode_i);
    assign hour_inc  = (in_run && min_carry) || (in_set_hour && btn_inc_i && !btn_mode_i);
    assign sec_clear = in_set_min && btn_mode_i;

    assign timeout_next = (timeout_cnt == TIMEOUT_MAX) ? timeout_cnt : timeout_cnt + TIMEOUT_W'(1);
    assign mode_o       = state;

    mod_counter #(.N(SEC_MOD), .W(SEC_W)) u_sec (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en  (sec_inc),
        .clear   (sec_clear),
        .value   (sec_o),
        .carry_o (sec_carry)
    );

    mod_counter #(.N(MIN_MOD), .W(MIN_W)) u_min (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en  (min_inc),
        .clear   (1'b0),
        .value   (min_o),
        .carry_o (min_carry)
    );

    mod_counter #(.N(HOURS_MOD), .W(HOUR_W)) u_hour (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_en  (hour_inc),
        .clear   (1'b0),
        .value   (hour_o),
        .carry_o (hour_carry_unused)
    );

    // Mode sequencing, blink generation and the idle timeout that drops back to RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= MODE_RUN;
            blink_o     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                MODE_RUN: begin
                    timeout_cnt <= '0;
                    blink_o     <= 1'b0;
                    if (btn_mode_i) begin
                        state   <= MODE_SET_HOUR;
                        blink_o <= 1'b1;
                    end
                end
                MODE_SET_HOUR, MODE_SET_MIN: begin
                    if (btn_mode_i) begin
                        timeout_cnt <= '0;
                        if (in_set_hour) begin
                            state   <= MODE_SET_MIN;
                            blink_o <= 1'b1;
                        end else begin
                            state   <= MODE_RUN;
                            blink_o <= 1'b0;
                        end
                    end else if (tick_i) begin
                        if (btn_inc_i) begin
                            timeout_cnt <= '0;
                            blink_o     <= ~blink_o;
                        end else if (timeout_next >= TIMEOUT_LIMIT) begin
                            state       <= MODE_RUN;
                            blink_o     <= 1'b0;
                            timeout_cnt <= '0;
                        end else begin
                            timeout_cnt <= timeout_next;
                            blink_o     <= ~blink_o;
                        end
                    end else if (btn_inc_i) begin
                        timeout_cnt <= '0;
                    end
                end
                default: begin
                    state       <= MODE_RUN;
                    blink_o     <= 1'b0;
                    timeout_cnt <= '0;
                end
            endcase
        end
    end

endmodule
